// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with loadable pattern and saturating match counter
module seq_detector_param #(
  parameter int              WIDTH   = 3,
  parameter logic [WIDTH-1:0] PATTERN = 3'b110,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             a,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic             clr_cnt,
  output logic             w,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);

  localparam int FW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] hist;
  logic [FW-1:0]    fill;
  logic [WIDTH-1:0] hist_n;
  logic [FW-1:0]    fill_n;
  logic             match;

  // fill saturates at WIDTH so a full history is only ever declared once WIDTH bits have arrived
  always_comb begin
    hist_n = {hist[WIDTH-2:0], a};
    fill_n = (fill == FW'(WIDTH)) ? fill : fill + FW'(1);
    match  = en && !load && (fill_n == FW'(WIDTH)) && (hist_n == pat);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat         <= PATTERN;
      hist        <= '0;
      fill        <= '0;
      w           <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (load) begin
        pat  <= pattern_in;
        hist <= '0;
        fill <= '0;
        w    <= 1'b0;
      end else if (en) begin
        hist <= hist_n;
        w    <= match;
        fill <= (match && !OVERLAP) ? '0 : fill_n;
      end else begin
        w <= 1'b0;
      end

      // a clear coinciding with a match counts that match
      if (clr_cnt) begin
        match_count <= match ? CNT_W'(1) : '0;
        overflow    <= 1'b0;
      end else if (match) begin
        if (&match_count) overflow <= 1'b1;
        else              match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule
